// File: rtl/load_store_unit_if.sv
// Bus bundle between the core, the load/store unit and the byte RAM port.
//
// Handshake rules: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where rsp_valid
// and rsp_ready are both 1. rsp_valid, once raised, stays high with
// rsp_rdata/rsp_error unchanged until that transfer.
//
// Modports:
//   slave  - the load/store unit (accepts requests, drives responses and RAM port)
//   master - the surrounding core/RAM (drives requests, accepts responses,
//            returns read data)
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mem_wr_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [1:0]  mem_by_wlen;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_en;
  logic [1:0]  mem_by_rlen;
  logic [31:0] mem_rd_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           mem_wr_addr, mem_wr_en, mem_wr_data, mem_by_wlen,
           mem_rd_addr, mem_rd_en, mem_by_rlen
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           mem_wr_addr, mem_wr_en, mem_wr_data, mem_by_wlen,
           mem_rd_addr, mem_rd_en, mem_by_rlen
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: converts RV32I load/store requests into single byte-lane
// RAM accesses, with range/funct3 checking and load sign/zero extension.
//
// Ports:
//   clk        - clock, all state on posedge
//   reset      - synchronous, active-high
//   bus        - load_store_unit_if.slave: request, response and RAM port
//   dbg_state  - current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Parameters: START_ADDRESS / STOP_ADDRESS bound the legal byte range (inclusive).
// Build option: define MISALIGN_TRAP_EN to report misaligned halfword/word
// accesses as errors instead of issuing them to the byte-addressed RAM.
//
// Flow: IDLE -> ACCESS -> RESP -> IDLE, one request in flight.
module load_store_unit #(
  parameter logic [31:0] START_ADDRESS = 32'd0,
  parameter logic [31:0] STOP_ADDRESS  = 32'd1023
) (
  input  logic                  clk,
  input  logic                  reset,
  load_store_unit_if.slave      bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic        op_we;
  logic [2:0]  op_f3;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [1:0]  op_len;     // bytes-1
  logic        op_err;
  logic [31:0] rdata_q;
  logic        err_q;

  // Request decode, evaluated on the incoming request in IDLE
  logic [1:0]  req_len;
  logic        f3_err;
  logic        lo_err;
  logic        hi_err;
  logic        mis_err;
  logic        req_err;
  logic [32:0] lo_diff;
  logic [32:0] last_addr;

  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00:   req_len = 2'b00;
      2'b01:   req_len = 2'b01;
      default: req_len = 2'b11;
    endcase
    if (bus.req_we)
      f3_err = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    else
      f3_err = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
               (bus.req_funct3 == 3'b111);
    // Borrow out of the 33-bit difference means addr < START_ADDRESS
    lo_diff   = {1'b0, bus.req_addr} - {1'b0, START_ADDRESS};
    lo_err    = lo_diff[32];
    // 33-bit sum so an access straddling 0xFFFFFFFF cannot wrap back into range
    last_addr = {1'b0, bus.req_addr} + {31'd0, req_len};
    hi_err    = last_addr > {1'b0, STOP_ADDRESS};
    mis_err   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis_err   = ((req_len == 2'b01) && bus.req_addr[0]) ||
                ((req_len == 2'b11) && (bus.req_addr[1:0] != 2'b00));
`endif
    req_err   = f3_err || lo_err || hi_err || mis_err;
  end

  // Load extension from the latched funct3
  logic [31:0] ext_data;
  always_comb begin
    case (op_f3)
      3'b000:  ext_data = {{24{bus.mem_rd_data[7]}}, bus.mem_rd_data[7:0]};
      3'b001:  ext_data = {{16{bus.mem_rd_data[15]}}, bus.mem_rd_data[15:0]};
      3'b100:  ext_data = {24'd0, bus.mem_rd_data[7:0]};
      3'b101:  ext_data = {16'd0, bus.mem_rd_data[15:0]};
      default: ext_data = bus.mem_rd_data;
    endcase
  end

  // RAM port: live only in ACCESS for a legal op; reset gates it
  // combinationally so a store interrupted by reset never commits.
  logic go;
  logic [31:0] wdata_masked;
  always_comb begin
    go = (state == ACCESS) && !op_err && !reset;
    case (op_len)
      2'b00:   wdata_masked = {24'd0, op_wdata[7:0]};
      2'b01:   wdata_masked = {16'd0, op_wdata[15:0]};
      default: wdata_masked = op_wdata;
    endcase
    bus.mem_wr_en   = go && op_we;
    bus.mem_wr_addr = (go && op_we) ? op_addr : 32'd0;
    bus.mem_wr_data = (go && op_we) ? wdata_masked : 32'd0;
    bus.mem_by_wlen = (go && op_we) ? op_len : 2'b00;
    bus.mem_rd_en   = go && !op_we;
    bus.mem_rd_addr = (go && !op_we) ? op_addr : 32'd0;
    bus.mem_by_rlen = (go && !op_we) ? op_len : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_we    <= 1'b0;
      op_f3    <= 3'd0;
      op_addr  <= 32'd0;
      op_wdata <= 32'd0;
      op_len   <= 2'b00;
      op_err   <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_we    <= bus.req_we;
            op_f3    <= bus.req_funct3;
            op_addr  <= bus.req_addr;
            op_wdata <= bus.req_wdata;
            op_len   <= req_len;
            op_err   <= req_err;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          err_q   <= op_err;
          rdata_q <= (!op_err && !op_we) ? ext_data : 32'd0;
          state   <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int RAM_BYTES = 1024;
  localparam longint START_A = 0;
  localparam longint STOP_A  = 1023;

  logic clk;
  logic reset;
  logic [1:0] dbg_state;
  load_store_unit_if bus_if();

  load_store_unit #(.START_ADDRESS(32'd0), .STOP_ADDRESS(32'd1023)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- byte RAM attached to the DUT ----------------
  bit [7:0] ram [0:RAM_BYTES-1];

  always @(posedge clk) begin
    if (bus_if.mem_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i <= int'(bus_if.mem_by_wlen) && (bus_if.mem_wr_addr + 32'(i)) < 32'(RAM_BYTES))
          ram[10'(bus_if.mem_wr_addr + 32'(i))] <= bus_if.mem_wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    bus_if.mem_rd_data = 32'd0;
    if (bus_if.mem_rd_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i <= int'(bus_if.mem_by_rlen) && (bus_if.mem_rd_addr + 32'(i)) < 32'(RAM_BYTES))
          bus_if.mem_rd_data[8*i +: 8] = ram[10'(bus_if.mem_rd_addr + 32'(i))];
      end
    end
  end

  // ---------------- reference model ----------------
  bit [7:0] ref_mem [0:RAM_BYTES-1];
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int op_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit exp_error(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    int sz;
    longint first;
    longint last;
    if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    sz    = op_size(f3);
    first = longint'({32'd0, addr});
    last  = first + longint'(sz) - 1;
    if (first < START_A || last > STOP_A) return 1'b1;
`ifdef MISALIGN_TRAP_EN
    if (sz > 1 && (first % sz) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr);
    int b;
    int h;
    int a;
    a = int'(addr);
    b = int'(ref_mem[a]);
    case (f3)
      3'd0: return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd4: return 32'(b);
      3'd1: begin
        h = b + 256 * int'(ref_mem[a + 1]);
        return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      end
      3'd5: return 32'(b + 256 * int'(ref_mem[a + 1]));
      default: return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
    endcase
  endfunction

  // ---------------- driver ----------------
  // Starts and ends on a falling edge; outputs are sampled on falling edges.
  task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int stall, input bit rst_in_access);
    bit err;
    int sz;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    err = exp_error(we, f3, addr);
    sz  = op_size(f3);
    exp_q.push_back((we || err) ? 32'd0 : exp_load(f3, addr));
    exp_wd = (sz == 4) ? wdata : (wdata & ((32'd1 << (8 * sz)) - 32'd1));

    bus_if.req_valid  = 1'b1;
    bus_if.req_we     = we;
    bus_if.req_funct3 = f3;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    #1 check("req_ready_idle", 32'(bus_if.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid = 1'b0;

    // ACCESS cycle
    check("rsp_valid_access", 32'(bus_if.rsp_valid), 32'd0);
    check("req_ready_access", 32'(bus_if.req_ready), 32'd0);
    check("rd_en", 32'(bus_if.mem_rd_en), 32'(!we && !err));
    check("wr_en", 32'(bus_if.mem_wr_en), 32'(we && !err));
    if (!err && !we) begin
      check("rd_addr", bus_if.mem_rd_addr, addr);
      check("rd_len", 32'(bus_if.mem_by_rlen), 32'(sz - 1));
    end
    if (!err && we) begin
      check("wr_addr", bus_if.mem_wr_addr, addr);
      check("wr_data", bus_if.mem_wr_data, exp_wd);
      check("wr_len", 32'(bus_if.mem_by_wlen), 32'(sz - 1));
    end

    if (rst_in_access) begin
      reset = 1'b1;
      #1 check("wr_en_under_reset", 32'(bus_if.mem_wr_en), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      void'(exp_q.pop_front());
      check("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus_if.rsp_rdata, 32'd0);
      check("rst_rsp_error", 32'(bus_if.rsp_error), 32'd0);
      check("rst_mem_en", {30'd0, bus_if.mem_wr_en, bus_if.mem_rd_en}, 32'd0);
      check("rst_mem_addr", bus_if.mem_wr_addr | bus_if.mem_rd_addr | bus_if.mem_wr_data, 32'd0);
      return;
    end

    if (we && !err)
      for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = exp_wd[8*i +: 8];
    @(posedge clk);
    @(negedge clk);

    // RESP: visible two edges after the handshake edge
    exp_rd = exp_q.pop_front();
    check("rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("rsp_error", 32'(bus_if.rsp_error), 32'(err));
    check("rsp_rdata", bus_if.rsp_rdata, exp_rd);
    check("req_ready_resp", 32'(bus_if.req_ready), 32'd0);
    check("mem_en_resp", {30'd0, bus_if.mem_wr_en, bus_if.mem_rd_en}, 32'd0);

    for (int i = 0; i < stall; i++) begin
      bus_if.req_valid = 1'($urandom_range(0, 1));
      bus_if.req_addr  = $urandom_range(0, 1023);
      @(posedge clk);
      @(negedge clk);
      check("stall_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
      check("stall_rsp_rdata", bus_if.rsp_rdata, exp_rd);
      check("stall_rsp_error", 32'(bus_if.rsp_error), 32'(err));
      check("stall_req_ready", 32'(bus_if.req_ready), 32'd0);
      check("stall_mem_en", {30'd0, bus_if.mem_wr_en, bus_if.mem_rd_en}, 32'd0);
    end
    bus_if.req_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    check("back_idle_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("back_idle_req_ready", 32'(bus_if.req_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.req_valid  = 1'b0;
    bus_if.req_we     = 1'b0;
    bus_if.req_funct3 = 3'd0;
    bus_if.req_addr   = 32'd0;
    bus_if.req_wdata  = 32'd0;
    bus_if.rsp_ready  = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("reset_req_ready", 32'(bus_if.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus_if.rsp_rdata, 32'd0);
    check("reset_rsp_error", 32'(bus_if.rsp_error), 32'd0);
    check("reset_mem_en", {30'd0, bus_if.mem_wr_en, bus_if.mem_rd_en}, 32'd0);

    // Directed cases
    do_op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0);   // SW
    do_op(1'b0, 3'd2, 32'h10, 32'd0, 0, 1'b0);          // LW
    check("dir_lw_value", exp_load(3'd2, 32'h10), 32'hDEADBEEF);
    do_op(1'b0, 3'd0, 32'h10, 32'd0, 0, 1'b0);          // LB
    do_op(1'b0, 3'd4, 32'h10, 32'd0, 0, 1'b0);          // LBU
    do_op(1'b0, 3'd1, 32'h12, 32'd0, 0, 1'b0);          // LH
    do_op(1'b0, 3'd5, 32'h12, 32'd0, 0, 1'b0);          // LHU
    do_op(1'b0, 3'd2, 32'h3FE, 32'd0, 0, 1'b0);         // LW out of range
    do_op(1'b1, 3'd0, 32'h3FF, 32'h000000A5, 0, 1'b0);  // SB at last byte
    do_op(1'b0, 3'd4, 32'h3FF, 32'd0, 0, 1'b0);
    do_op(1'b0, 3'd2, 32'h11, 32'd0, 0, 1'b0);          // misaligned LW
    do_op(1'b0, 3'd3, 32'h20, 32'd0, 0, 1'b0);          // illegal load funct3
    do_op(1'b1, 3'd4, 32'h20, 32'h11223344, 0, 1'b0);   // illegal store funct3
    do_op(1'b0, 3'd2, 32'hFFFFFFFE, 32'd0, 0, 1'b0);    // would wrap
    do_op(1'b0, 3'd2, 32'h10, 32'd0, 5, 1'b0);          // held response
    do_op(1'b1, 3'd2, 32'h20, 32'h12345678, 0, 1'b1);   // reset during store
    do_op(1'b0, 3'd2, 32'h20, 32'd0, 0, 1'b0);          // location untouched

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0, 1: a = $urandom_range(0, 63);
        2:    a = $urandom_range(1016, 1023);
        3:    a = $urandom_range(0, 1023);
        default: a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      endcase
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on simulation length
  initial begin
    #2000000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
    $fatal(1, "simulation time limit");
  end

endmodule
